// File: rtl/iiitb_brg_pkg.sv
// Shared definitions for the baud-rate generator and the autobaud detector:
// divisor defaults, rate-select encoding, per-rate bit-period windows, FSM states.
package iiitb_brg_pkg;

  localparam int unsigned DIV1_DEF     = 34;
  localparam int unsigned OVS_DEF      = 16;
  localparam int unsigned IDLE_CYC_DEF = 256;
  localparam int unsigned CW_DEF       = 16;
  localparam int unsigned NBINS        = 4;

  localparam logic [1:0] SEL_115200 = 2'b00;
  localparam logic [1:0] SEL_38400  = 2'b01;
  localparam logic [1:0] SEL_19200  = 2'b10;
  localparam logic [1:0] SEL_9600   = 2'b11;

  localparam logic [1:0] BIN_SEL [NBINS] = '{SEL_115200, SEL_38400, SEL_19200, SEL_9600};

  // Bit period in system clocks is 2*DIV1*OVS*M, M per rate bin.
  function automatic int unsigned bin_mult(input int unsigned b);
    case (b)
      0:       return 1;
      1:       return 3;
      2:       return 6;
      default: return 12;
    endcase
  endfunction

  function automatic int unsigned bin_nom(input int unsigned div1, input int unsigned ovs,
                                          input int unsigned b);
    return 2 * div1 * ovs * bin_mult(b);
  endfunction

  // Acceptance window is nominal +/- 1/8, inclusive.
  function automatic int unsigned bin_min(input int unsigned div1, input int unsigned ovs,
                                          input int unsigned b);
    return bin_nom(div1, ovs, b) - bin_nom(div1, ovs, b) / 8;
  endfunction

  function automatic int unsigned bin_max(input int unsigned div1, input int unsigned ovs,
                                          input int unsigned b);
    return bin_nom(div1, ovs, b) + bin_nom(div1, ovs, b) / 8;
  endfunction

  localparam int unsigned BIN_MIN [NBINS] = '{
    bin_min(DIV1_DEF, OVS_DEF, 0), bin_min(DIV1_DEF, OVS_DEF, 1),
    bin_min(DIV1_DEF, OVS_DEF, 2), bin_min(DIV1_DEF, OVS_DEF, 3)};
  localparam int unsigned BIN_MAX [NBINS] = '{
    bin_max(DIV1_DEF, OVS_DEF, 0), bin_max(DIV1_DEF, OVS_DEF, 1),
    bin_max(DIV1_DEF, OVS_DEF, 2), bin_max(DIV1_DEF, OVS_DEF, 3)};

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    ARMED     = 3'd1,
    MEASURE   = 3'd2,
    VERIFY    = 3'd3,
    STOP      = 3'd4,
    LOCKED    = 3'd5
  } abd_state_e;

endpackage

// File: rtl/iiitb_abd_sync_edge.sv
// Two-flop synchronizer for the raw RX line with single-cycle rise/fall strobes.
// Resets to the idle (high) level so no edge is seen when reset releases.
module iiitb_abd_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic meta;
  logic q_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b1;
      q      <= 1'b1;
      q_prev <= 1'b1;
    end else begin
      meta   <= d;
      q      <= meta;
      q_prev <= q;
    end
  end

  assign rise_c = q & ~q_prev;
  assign fall_c = ~q & q_prev;

endmodule

// File: rtl/iiitb_autobaud.sv
// Autobaud detector: measures a 0x55 sync character on rxd and reports the
// matching generator rate select once every pulse of the frame has been verified.
module iiitb_autobaud
  import iiitb_brg_pkg::*;
#(
  parameter int unsigned DIV1     = DIV1_DEF,
  parameter int unsigned OVS      = OVS_DEF,
  parameter int unsigned IDLE_CYC = IDLE_CYC_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rearm,
  output logic [1:0] sel,
  output logic       locked,
  output logic       err
);

  localparam int unsigned IW = $clog2(IDLE_CYC + 1);
  localparam logic [IW-1:0] IDLE_DONE = IW'(IDLE_CYC);
  localparam logic [CW-1:0] CNT_SAT   = '1;
  localparam logic [3:0]    LAST_PULSE = 4'd8;

  localparam logic [CW-1:0] WMIN [NBINS] = '{
    CW'(bin_min(DIV1, OVS, 0)), CW'(bin_min(DIV1, OVS, 1)),
    CW'(bin_min(DIV1, OVS, 2)), CW'(bin_min(DIV1, OVS, 3))};
  localparam logic [CW-1:0] WMAX [NBINS] = '{
    CW'(bin_max(DIV1, OVS, 0)), CW'(bin_max(DIV1, OVS, 1)),
    CW'(bin_max(DIV1, OVS, 2)), CW'(bin_max(DIV1, OVS, 3))};

  abd_state_e state, state_d;
  logic [1:0]    bin_q, bin_d;
  logic [3:0]    idx, idx_d;
  logic [1:0]    sel_d;
  logic          locked_d;
  logic          err_d;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idle_cnt;

  logic          rx_s;
  logic          rise_c;
  logic          fall_c;
  logic          hit_c;
  logic [1:0]    hit_bin_c;
  logic [CW-1:0] cur_min_c;
  logic [CW-1:0] cur_max_c;
  logic          in_win_c;

  iiitb_abd_sync_edge u_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (rxd),
    .q      (rx_s),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Pulse-width counter: holds the width of the pulse just ended on each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (rise_c || fall_c)  cnt <= CW'(1);
    else if (cnt != CNT_SAT)    cnt <= cnt + CW'(1);
  end

  // Idle qualification only counts while hunting, so a long data bit cannot arm us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             idle_cnt <= '0;
    else if (state != WAIT_IDLE || !rx_s)  idle_cnt <= '0;
    else if (idle_cnt != IDLE_DONE)        idle_cnt <= idle_cnt + IW'(1);
  end

  always_comb begin
    hit_c     = 1'b0;
    hit_bin_c = '0;
    for (int unsigned i = 0; i < NBINS; i++) begin
      if (cnt >= WMIN[i] && cnt <= WMAX[i]) begin
        hit_c     = 1'b1;
        hit_bin_c = 2'(i);
      end
    end
  end

  assign cur_min_c = WMIN[bin_q];
  assign cur_max_c = WMAX[bin_q];
  assign in_win_c  = (cnt >= cur_min_c) && (cnt <= cur_max_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= WAIT_IDLE;
      bin_q  <= '0;
      idx    <= '0;
      sel    <= SEL_115200;
      locked <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_d;
      bin_q  <= bin_d;
      idx    <= idx_d;
      sel    <= sel_d;
      locked <= locked_d;
      err    <= err_d;
    end
  end

  always_comb begin
    state_d  = state;
    bin_d    = bin_q;
    idx_d    = idx;
    sel_d    = sel;
    locked_d = locked;
    err_d    = 1'b0;

    case (state)
      WAIT_IDLE: if (idle_cnt == IDLE_DONE) state_d = ARMED;

      ARMED: if (fall_c) state_d = MEASURE;

      MEASURE: begin
        if (rise_c) begin
          if (hit_c) begin
            bin_d   = hit_bin_c;
            idx_d   = 4'd1;
            state_d = VERIFY;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else if (cnt > WMAX[NBINS-1]) begin
          err_d   = 1'b1;
          state_d = WAIT_IDLE;
        end
      end

      // Data pulses of 0x55 alternate, so every edge closes one bit.
      VERIFY: begin
        if (rise_c || fall_c) begin
          if (!in_win_c) begin
            err_d   = 1'b1;
            state_d = WAIT_IDLE;
          end else if (idx == LAST_PULSE) begin
            state_d = STOP;
          end else begin
            idx_d = idx + 4'd1;
          end
        end else if (cnt > cur_max_c) begin
          err_d   = 1'b1;
          state_d = WAIT_IDLE;
        end
      end

      // Lock is registered on the cycle the counter reaches the bin minimum.
      STOP: begin
        if (fall_c) begin
          err_d   = 1'b1;
          state_d = WAIT_IDLE;
        end else if (cnt == cur_min_c - CW'(1)) begin
          sel_d    = BIN_SEL[bin_q];
          locked_d = 1'b1;
          state_d  = LOCKED;
        end
      end

      LOCKED: ;

      default: state_d = WAIT_IDLE;
    endcase

    // Rearm overrides everything, including a lock landing in the same cycle.
    if (rearm) begin
      state_d  = WAIT_IDLE;
      sel_d    = sel;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_iiitb_autobaud.sv
// Bench for iiitb_autobaud: directed scenarios plus random 0x55 frames judged by a
// pulse-width model. The DUT runs with a small DIV1 so full frames stay short.
module tb_iiitb_autobaud;

  localparam int unsigned TDIV1 = 4;
  localparam int unsigned TOVS  = 16;
  localparam int unsigned TIDLE = 256;

  typedef int frame_t [10];

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rearm;
  logic [1:0] sel;
  logic       locked;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cycles = 0;
  int cur_sel = 0;

  iiitb_autobaud #(
    .DIV1     (TDIV1),
    .OVS      (TOVS),
    .IDLE_CYC (TIDLE),
    .CW       (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rxd    (rxd),
    .rearm  (rearm),
    .sel    (sel),
    .locked (locked),
    .err    (err)
  );

  always #4 clk = ~clk;

  always @(negedge clk) if (err === 1'b1) err_cycles++;

  // Reference arithmetic: nominal period and +/-1/8 window per rate bin.
  function automatic int nom(input int b);
    int m;
    case (b)
      0:       m = 1;
      1:       m = 3;
      2:       m = 6;
      default: m = 12;
    endcase
    return int'(2 * TDIV1 * TOVS) * m;
  endfunction

  function automatic int lo(input int b);
    return nom(b) - nom(b) / 8;
  endfunction

  function automatic int hi(input int b);
    return nom(b) + nom(b) / 8;
  endfunction

  function automatic frame_t nominal_frame(input int b);
    frame_t w;
    for (int i = 0; i < 10; i++) w[i] = nom(b);
    return w;
  endfunction

  function automatic frame_t random_frame(input int b);
    frame_t w;
    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(3, 0))
        0:       w[i] = lo(b);
        1:       w[i] = hi(b);
        default: w[i] = int'($urandom_range(hi(b), lo(b)));
      endcase
    end
    return w;
  endfunction

  // Frame judge: w[0] start (low), w[1..8] data bits, w[9] stop (high).
  // Reports the expected error count, lock, resulting sel, and how many
  // segments a sender transmits before the detector gives up.
  function automatic void judge(input frame_t w, input int prev_sel, output int e,
                                output int l, output int s, output int ns);
    int b;
    b  = -1;
    e  = 0;
    l  = 0;
    s  = prev_sel;
    ns = 10;
    for (int k = 0; k < 4; k++) if (w[0] >= lo(k) && w[0] <= hi(k)) b = k;
    if (b < 0) begin
      e  = 1;
      ns = 1;
      return;
    end
    for (int i = 1; i < 9; i++) begin
      if (w[i] < lo(b) || w[i] > hi(b)) begin
        e  = 1;
        ns = i + 1;
        return;
      end
    end
    if (w[9] < lo(b)) begin
      e = 1;
      return;
    end
    l = 1;
    s = b;
  endfunction

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_rearm();
    rxd   = 1'b1;
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
  endtask

  // Drives the first ns segments, then briefly the following level, then idle high.
  task automatic send(input frame_t w, input int ns);
    logic lvl;
    lvl = 1'b0;
    for (int i = 0; i < ns; i++) begin
      rxd = lvl;
      repeat (w[i]) @(negedge clk);
      lvl = ~lvl;
    end
    rxd = lvl;
    repeat (50) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rxd   = 1'b1;
    rearm = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (sel !== 2'b00) begin n_bad++; $display("FAIL reset_sel: got %b expected 00", sel); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Lock lands lo(0) cycles after the stop-bit edge, plus two synchronizer cycles.
  task automatic test_lock_timing();
    int e0, k;
    idle(300);
    e0 = err_cycles;
    for (int i = 0; i < 9; i++) begin
      rxd = (i % 2 == 1) ? 1'b1 : 1'b0;
      repeat (nom(0)) @(negedge clk);
    end
    rxd = 1'b1;
    k = 0;
    while (k < 2 * hi(0) && locked !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (k != lo(0) + 2) begin n_bad++; $display("FAIL lock_latency: got %0d cycles expected %0d", k, lo(0) + 2); end
    n_cmp++; if (sel !== 2'b00) begin n_bad++; $display("FAIL lock_sel: got %b expected 00", sel); end
    n_cmp++; if (err_cycles != e0) begin n_bad++; $display("FAIL lock_no_err: got %0d err cycles expected 0", err_cycles - e0); end
    cur_sel = 0;
    idle(100);
  endtask

  task automatic test_rates();
    int order [3] = '{3, 1, 2};
    int e0;
    for (int j = 0; j < 3; j++) begin
      do_rearm();
      idle(300);
      e0 = err_cycles;
      send(nominal_frame(order[j]), 10);
      n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rate_locked bin%0d: got %b expected 1", order[j], locked); end
      n_cmp++; if (sel !== 2'(order[j])) begin n_bad++; $display("FAIL rate_sel bin%0d: got %0d expected %0d", order[j], sel, order[j]); end
      n_cmp++; if (err_cycles != e0) begin n_bad++; $display("FAIL rate_err bin%0d: got %0d expected 0", order[j], err_cycles - e0); end
      cur_sel = order[j];
    end
  endtask

  task automatic test_locked_ignore();
    int e0;
    e0 = err_cycles;
    for (int i = 0; i < 40; i++) begin
      rxd = 1'($urandom_range(1, 0));
      repeat ($urandom_range(20, 1)) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL ignore_locked: got %b expected 1", locked); end
    n_cmp++; if (sel !== 2'b10) begin n_bad++; $display("FAIL ignore_sel: got %b expected 10", sel); end
    n_cmp++; if (err_cycles != e0) begin n_bad++; $display("FAIL ignore_err: got %0d expected 0", err_cycles - e0); end
    do_rearm();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rearm_locked: got %b expected 0", locked); end
    n_cmp++; if (sel !== 2'b10) begin n_bad++; $display("FAIL rearm_sel_hold: got %b expected 10", sel); end
    idle(300);
    send(nominal_frame(0), 10);
    n_cmp++; if (locked !== 1'b1 || sel !== 2'b00) begin n_bad++; $display("FAIL relock: got locked=%b sel=%b expected 1/00", locked, sel); end
    cur_sel = 0;
  endtask

  task automatic test_bad_start();
    frame_t w;
    int e0;
    do_rearm();
    idle(300);
    e0 = err_cycles;
    w = nominal_frame(0);
    w[0] = (hi(0) + lo(1)) / 2;
    send(w, 1);
    n_cmp++; if (err_cycles - e0 != 1) begin n_bad++; $display("FAIL badstart_err: got %0d err cycles expected 1", err_cycles - e0); end
    n_cmp++; if (locked !== 1'b0 || sel !== 2'(cur_sel)) begin n_bad++; $display("FAIL badstart_hold: got locked=%b sel=%0d expected 0/%0d", locked, sel, cur_sel); end
    idle(300);
    e0 = err_cycles;
    send(random_frame(1), 10);
    n_cmp++; if (locked !== 1'b1 || sel !== 2'b01) begin n_bad++; $display("FAIL badstart_relock: got locked=%b sel=%b expected 1/01", locked, sel); end
    n_cmp++; if (err_cycles != e0) begin n_bad++; $display("FAIL badstart_relock_err: got %0d expected 0", err_cycles - e0); end
    cur_sel = 1;
  endtask

  task automatic test_reset_mid_verify();
    int e0;
    do_rearm();
    idle(300);
    e0 = err_cycles;
    for (int i = 0; i < 5; i++) begin
      rxd = (i % 2 == 1) ? 1'b1 : 1'b0;
      repeat (nom(0)) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_cmp++; if (sel !== 2'b00 || locked !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL midreset_outputs: got sel=%b locked=%b err=%b expected 00/0/0", sel, locked, err); end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(300);
    n_cmp++; if (err_cycles != e0) begin n_bad++; $display("FAIL midreset_err: got %0d expected 0", err_cycles - e0); end
    send(random_frame(1), 10);
    n_cmp++; if (locked !== 1'b1 || sel !== 2'b01) begin n_bad++; $display("FAIL midreset_relock: got locked=%b sel=%b expected 1/01", locked, sel); end
    cur_sel = 1;
  endtask

  // Over-long bit and line break: err fires as soon as the count passes the window top.
  task automatic test_overlong();
    frame_t w;
    int e0, k, ee, el, es, ens;
    do_rearm();
    idle(300);
    e0 = err_cycles;
    w = nominal_frame(0);
    w[4] = hi(0) + 16;
    judge(w, cur_sel, ee, el, es, ens);
    send(w, ens);
    n_cmp++; if (err_cycles - e0 != ee) begin n_bad++; $display("FAIL stretch_err: got %0d expected %0d", err_cycles - e0, ee); end
    n_cmp++; if (locked !== 1'b0 || sel !== 2'(cur_sel)) begin n_bad++; $display("FAIL stretch_hold: got locked=%b sel=%0d expected 0/%0d", locked, sel, cur_sel); end
    idle(300);
    e0 = err_cycles;
    rxd = 1'b0;
    k = 0;
    while (k < hi(3) + 100 && err !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    n_cmp++; if (k != hi(3) + 4) begin n_bad++; $display("FAIL break_latency: got %0d cycles expected %0d", k, hi(3) + 4); end
    repeat (200) @(negedge clk);
    idle(50);
    n_cmp++; if (err_cycles - e0 != 1) begin n_bad++; $display("FAIL break_err: got %0d expected 1", err_cycles - e0); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL break_locked: got %b expected 0", locked); end
  endtask

  task automatic test_random();
    frame_t w;
    int b, k, e0, ee, el, es, ens;
    for (int t = 0; t < 6; t++) begin
      b = int'($urandom_range(1, 0));
      w = random_frame(b);
      if ($urandom_range(1, 0) == 1) begin
        k = int'($urandom_range(9, 0));
        if ($urandom_range(1, 0) == 1) w[k] = hi(b) + 1 + int'($urandom_range(40, 0));
        else                           w[k] = lo(b) - 1 - int'($urandom_range(40, 0));
      end
      judge(w, cur_sel, ee, el, es, ens);
      do_rearm();
      idle(300);
      e0 = err_cycles;
      send(w, ens);
      n_cmp++; if (err_cycles - e0 != ee) begin n_bad++; $display("FAIL rand%0d_err: got %0d expected %0d", t, err_cycles - e0, ee); end
      n_cmp++; if (locked !== 1'(el)) begin n_bad++; $display("FAIL rand%0d_locked: got %b expected %0d", t, locked, el); end
      n_cmp++; if (sel !== 2'(es)) begin n_bad++; $display("FAIL rand%0d_sel: got %0d expected %0d", t, sel, es); end
      cur_sel = es;
    end
  endtask

  initial begin
    test_reset();
    test_lock_timing();
    test_rates();
    test_locked_ignore();
    test_bad_start();
    test_reset_mid_verify();
    test_overlong();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
